// File: rtl/usr_serial_ctrl.sv
// Serial sequencing controller: accepts a parallel word over valid/ready, then
// drives a universal shift register to stream it out one bit per accepted beat.
module usr_serial_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_in_data,
   input  logic             i_in_dir,
   input  logic             i_ser_ready,
   output logic             o_ser_valid,
   output logic             o_ser_out,
   input  logic             i_abort,
   output logic             o_busy,
   output logic             o_done,
   output logic [1:0]       o_mode_out
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_LOAD = 2'b01;
   localparam logic [1:0] MODE_SHR  = 2'b10;
   localparam logic [1:0] MODE_SHL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_nxt;
   logic             r_dir;
   logic             w_dir_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [1:0]       w_mode;
   logic             w_clr;

   // State and datapath registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_q     <= {WIDTH{1'b0}};
         r_dir   <= 1'b0;
         r_cnt   <= CNT_ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_dir   <= w_dir_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state, register mode selection and handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_mode      = MODE_HOLD;
      w_clr       = 1'b0;
      w_dir_nxt   = r_dir;
      w_cnt_nxt   = r_cnt;
      o_in_ready  = 1'b0;
      o_ser_valid = 1'b0;
      o_ser_out   = 1'b0;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_in_ready = 1'b1;
            if (i_in_valid) begin
               w_mode      = MODE_LOAD;
               w_dir_nxt   = i_in_dir;
               w_cnt_nxt   = CNT_ZERO;
               w_state_nxt = ST_SHIFT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            o_ser_valid = 1'b1;
            o_busy      = 1'b1;
            o_ser_out   = r_dir ? r_q[WIDTH-1] : r_q[0];
            // abort wins over an accepted beat; the in-flight bit is dropped
            if (i_abort) begin
               w_clr       = 1'b1;
               w_cnt_nxt   = CNT_ZERO;
               w_state_nxt = ST_IDLE;
            end else if (i_ser_ready) begin
               w_mode      = r_dir ? MODE_SHL : MODE_SHR;
               w_cnt_nxt   = r_cnt + CNT_ONE;
               w_state_nxt = (r_cnt == CNT_LAST) ? ST_DONE : ST_SHIFT;
            end else begin
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_DONE: begin
            o_done      = 1'b1;
            o_busy      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_clr       = 1'b1;
            w_cnt_nxt   = CNT_ZERO;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Universal shift register: hold / load / shift right / shift left.
   always_comb begin
      w_q_nxt = r_q;
      if (w_clr) begin
         w_q_nxt = {WIDTH{1'b0}};
      end else begin
         case (w_mode)
            MODE_LOAD: w_q_nxt = i_in_data;
            MODE_SHR:  w_q_nxt = {1'b0, r_q[WIDTH-1:1]};
            MODE_SHL:  w_q_nxt = {r_q[WIDTH-2:0], 1'b0};
            default:   w_q_nxt = r_q;
         endcase
      end
   end

   assign o_mode_out = w_mode;

endmodule
